// File: rtl/ysyx_040729_trap_ctrl.sv
// Trap sequencer: detects traps/mret at commit, drains the LSU, strobes the CSR file and redirects fetch.
// Optional: define YSYX_040729_TRAP_VECTORED_EN for vectored interrupt targets when mtvec[1:0]==2'b01.
module ysyx_040729_trap_ctrl #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned CAUSE_EXT  = 11,
    parameter int unsigned CAUSE_TMR  = 7
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  commit_valid,
    input  logic [DATA_WIDTH-1:0] commit_pc,
    input  logic [DATA_WIDTH-1:0] commit_npc,
    input  logic                  commit_ecall,
    input  logic                  commit_ebreak,
    input  logic                  commit_illegal,
    input  logic                  commit_mret,
    input  logic                  eirp,
    input  logic                  tirp,
    input  logic                  lsu_busy,
    input  logic [DATA_WIDTH-1:0] mtvec,
    input  logic [DATA_WIDTH-1:0] mepc,
    output logic                  csr_exception,
    output logic                  csr_mret,
    output logic [DATA_WIDTH-1:0] csr_mepc_hwdata,
    output logic [DATA_WIDTH-1:0] csr_mcause_hwdata,
    output logic                  stall,
    output logic                  redirect_valid,
    output logic [DATA_WIDTH-1:0] redirect_pc,
    input  logic                  redirect_ready
);

    localparam int unsigned W            = DATA_WIDTH;
    localparam int unsigned CW           = DATA_WIDTH - 1;
    localparam int unsigned CODE_ILLEGAL = 2;
    localparam int unsigned CODE_EBREAK  = 3;
    localparam int unsigned CODE_ECALL   = 11;

    typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_FIRE, S_REDIR} state_t;

    state_t         state, state_n;
    logic           cap_mret, cap_mret_n;
    logic [W-1:0]   cap_mepc, cap_mepc_n;
    logic [W-1:0]   cap_cause, cap_cause_n;
    logic           exc_n, mret_n, rv_n;
    logic [W-1:0]   mepc_hw_n, mcause_hw_n, rpc_n;
    logic           det_any, det_mret, event_c;
    logic [W-1:0]   det_mepc, det_cause;
    logic [W-1:0]   trap_base, trap_target;

    // Priority encode of the committing instruction's event
    always_comb begin
        det_any   = 1'b1;
        det_mret  = 1'b0;
        det_mepc  = commit_pc;
        det_cause = '0;
        if (commit_illegal)     det_cause = W'(CODE_ILLEGAL);
        else if (commit_ebreak) det_cause = W'(CODE_EBREAK);
        else if (commit_ecall)  det_cause = W'(CODE_ECALL);
        else if (commit_mret)   det_mret  = 1'b1;
        else if (eirp) begin
            det_mepc  = commit_npc;
            det_cause = {1'b1, CW'(CAUSE_EXT)};
        end else if (tirp) begin
            det_mepc  = commit_npc;
            det_cause = {1'b1, CW'(CAUSE_TMR)};
        end else begin
            det_any = 1'b0;
        end
    end

    assign trap_base = {mtvec[W-1:2], 2'b00};
`ifdef YSYX_040729_TRAP_VECTORED_EN
    assign trap_target = (cap_cause[W-1] && (mtvec[1:0] == 2'b01))
                       ? trap_base + {cap_cause[W-3:0], 2'b00} : trap_base;
`else
    logic unused_mtvec_mode;
    assign unused_mtvec_mode = ^mtvec[1:0];
    assign trap_target = trap_base;
`endif

    assign event_c = (state == S_IDLE) && commit_valid && det_any;
    assign stall   = reset && (event_c || (state != S_IDLE));

    // Next state, capture and registered output values
    always_comb begin
        state_n     = state;
        cap_mret_n  = cap_mret;
        cap_mepc_n  = cap_mepc;
        cap_cause_n = cap_cause;
        exc_n       = 1'b0;
        mret_n      = 1'b0;
        mepc_hw_n   = '0;
        mcause_hw_n = '0;
        rv_n        = 1'b0;
        rpc_n       = '0;
        case (state)
            S_IDLE: begin
                if (event_c) begin
                    cap_mret_n  = det_mret;
                    cap_mepc_n  = det_mret ? '0 : det_mepc;
                    cap_cause_n = det_mret ? '0 : det_cause;
                    state_n     = lsu_busy ? S_DRAIN : S_FIRE;
                end
            end
            S_DRAIN: begin
                if (!lsu_busy) state_n = S_FIRE;
            end
            S_FIRE: begin
                state_n = S_REDIR;
                rv_n    = 1'b1;
                rpc_n   = cap_mret ? mepc : trap_target;
            end
            S_REDIR: begin
                if (redirect_ready) begin
                    state_n = S_IDLE;
                end else begin
                    rv_n  = 1'b1;
                    rpc_n = redirect_pc;
                end
            end
            default: state_n = S_IDLE;
        endcase
        // Strobes are registered so they line up with the FIRE state
        if (state_n == S_FIRE) begin
            exc_n  = !cap_mret_n;
            mret_n = cap_mret_n;
            if (!cap_mret_n) begin
                mepc_hw_n   = cap_mepc_n;
                mcause_hw_n = cap_cause_n;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state             <= S_IDLE;
            cap_mret          <= 1'b0;
            cap_mepc          <= '0;
            cap_cause         <= '0;
            csr_exception     <= 1'b0;
            csr_mret          <= 1'b0;
            csr_mepc_hwdata   <= '0;
            csr_mcause_hwdata <= '0;
            redirect_valid    <= 1'b0;
            redirect_pc       <= '0;
        end else begin
            state             <= state_n;
            cap_mret          <= cap_mret_n;
            cap_mepc          <= cap_mepc_n;
            cap_cause         <= cap_cause_n;
            csr_exception     <= exc_n;
            csr_mret          <= mret_n;
            csr_mepc_hwdata   <= mepc_hw_n;
            csr_mcause_hwdata <= mcause_hw_n;
            redirect_valid    <= rv_n;
            redirect_pc       <= rpc_n;
        end
    end

endmodule

// File: tb/tb_ysyx_040729_trap_ctrl.sv
// Self-checking bench for ysyx_040729_trap_ctrl: directed plan items plus randomized transactions.
module tb_ysyx_040729_trap_ctrl;

`ifdef YSYX_040729_TRAP_VECTORED_EN
    localparam bit VEC = 1'b1;
`else
    localparam bit VEC = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        commit_valid = 1'b0;
    logic [63:0] commit_pc = '0, commit_npc = '0;
    logic        commit_ecall = 1'b0, commit_ebreak = 1'b0, commit_illegal = 1'b0, commit_mret = 1'b0;
    logic        eirp = 1'b0, tirp = 1'b0, lsu_busy = 1'b0;
    logic [63:0] mtvec = '0, mepc = '0;
    logic        csr_exception, csr_mret, stall, redirect_valid;
    logic [63:0] csr_mepc_hwdata, csr_mcause_hwdata, redirect_pc;
    logic        redirect_ready = 1'b0;

    int tests = 0;
    int fails = 0;

    ysyx_040729_trap_ctrl dut (
        .clock(clock), .reset(reset),
        .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_npc(commit_npc),
        .commit_ecall(commit_ecall), .commit_ebreak(commit_ebreak),
        .commit_illegal(commit_illegal), .commit_mret(commit_mret),
        .eirp(eirp), .tirp(tirp), .lsu_busy(lsu_busy),
        .mtvec(mtvec), .mepc(mepc),
        .csr_exception(csr_exception), .csr_mret(csr_mret),
        .csr_mepc_hwdata(csr_mepc_hwdata), .csr_mcause_hwdata(csr_mcause_hwdata),
        .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .redirect_ready(redirect_ready)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stall"}, 64'(stall), 64'd0);
        chk({tag, "_exc"}, 64'(csr_exception), 64'd0);
        chk({tag, "_mret"}, 64'(csr_mret), 64'd0);
        chk({tag, "_mepc_hw"}, csr_mepc_hwdata, 64'd0);
        chk({tag, "_mcause_hw"}, csr_mcause_hwdata, 64'd0);
        chk({tag, "_rv"}, 64'(redirect_valid), 64'd0);
        chk({tag, "_rpc"}, redirect_pc, 64'd0);
    endtask

    // Garbage on commit/irq lines while the pipeline is frozen; must be ignored
    task automatic junk();
        commit_valid   = 1'($urandom);
        commit_pc      = {$urandom, $urandom};
        commit_npc     = {$urandom, $urandom};
        commit_ecall   = 1'($urandom);
        commit_ebreak  = 1'($urandom);
        commit_illegal = 1'($urandom);
        commit_mret    = 1'($urandom);
        eirp           = 1'($urandom);
        tirp           = 1'($urandom);
    endtask

    task automatic quiet();
        commit_valid = 1'b0;
        {commit_ecall, commit_ebreak, commit_illegal, commit_mret} = 4'b0;
        eirp = 1'b0;
        tirp = 1'b0;
    endtask

    // Reference: kind 0 none, 1 trap, 2 mret
    task automatic model(input logic ill, ebr, ecl, mrt, e, t, input logic [63:0] pc, npc, mtv,
                         output int kind, output logic [63:0] em, ec, tgt);
        logic [63:0] code;
        logic irq;
        irq = 1'b0; kind = 1; em = pc; code = 0;
        if (ill)      code = 2;
        else if (ebr) code = 3;
        else if (ecl) code = 11;
        else if (mrt) kind = 2;
        else if (e) begin irq = 1'b1; code = 11; em = npc; end
        else if (t) begin irq = 1'b1; code = 7;  em = npc; end
        else kind = 0;
        ec  = irq ? (64'h1 << 63) + code : code;
        tgt = mtv - (mtv % 4);
        if (VEC && irq && (mtv % 4 == 1)) tgt = tgt + 4 * code;
        if (kind == 2) begin em = 0; ec = 0; end
    endtask

    task automatic run_txn(input logic [63:0] pc, npc, input logic ill, ebr, ecl, mrt, e, t,
                           input logic [63:0] mtv, mep_fire, input int d, w);
        int kind;
        logic [63:0] em, ec, tgt;
        model(ill, ebr, ecl, mrt, e, t, pc, npc, mtv, kind, em, ec, tgt);
        commit_valid = 1'b1; commit_pc = pc; commit_npc = npc;
        commit_illegal = ill; commit_ebreak = ebr; commit_ecall = ecl; commit_mret = mrt;
        eirp = e; tirp = t; mtvec = mtv; mepc = {$urandom, $urandom};
        lsu_busy = (d > 0); redirect_ready = 1'($urandom);
        #1;
        if (kind == 0) begin
            chk("plain_stall", 64'(stall), 64'd0);
            tick();
            quiet();
            #1;
            chk("plain_after_stall", 64'(stall), 64'd0);
            chk("plain_after_rv", 64'(redirect_valid), 64'd0);
            chk("plain_after_exc", 64'(csr_exception), 64'd0);
            return;
        end
        chk("commit_stall", 64'(stall), 64'd1);
        chk("commit_exc", 64'(csr_exception), 64'd0);
        chk("commit_rv", 64'(redirect_valid), 64'd0);
        tick();
        for (int i = 0; i < d; i++) begin
            junk();
            lsu_busy = (i < d - 1);
            #1;
            chk("drain_stall", 64'(stall), 64'd1);
            chk("drain_exc", 64'(csr_exception), 64'd0);
            chk("drain_mret", 64'(csr_mret), 64'd0);
            chk("drain_rv", 64'(redirect_valid), 64'd0);
            tick();
        end
        junk();
        lsu_busy = 1'($urandom);
        mepc = mep_fire;
        if (kind == 2) tgt = mep_fire;
        #1;
        chk("fire_exc", 64'(csr_exception), (kind == 1) ? 64'd1 : 64'd0);
        chk("fire_mret", 64'(csr_mret), (kind == 2) ? 64'd1 : 64'd0);
        chk("fire_mepc_hw", csr_mepc_hwdata, em);
        chk("fire_mcause_hw", csr_mcause_hwdata, ec);
        chk("fire_rv", 64'(redirect_valid), 64'd0);
        chk("fire_stall", 64'(stall), 64'd1);
        tick();
        for (int j = 0; j <= w; j++) begin
            if (j == w) begin quiet(); redirect_ready = 1'b1; end
            else begin junk(); redirect_ready = 1'b0; end
            mepc = {$urandom, $urandom};
            #1;
            chk("redir_rv", 64'(redirect_valid), 64'd1);
            chk("redir_pc", redirect_pc, tgt);
            chk("redir_exc", 64'(csr_exception), 64'd0);
            chk("redir_mret", 64'(csr_mret), 64'd0);
            chk("redir_stall", 64'(stall), 64'd1);
            chk("redir_mepc_hw", csr_mepc_hwdata, 64'd0);
            tick();
        end
        redirect_ready = 1'($urandom);
        lsu_busy = 1'($urandom);
        #1;
        chk("done_stall", 64'(stall), 64'd0);
        chk("done_rv", 64'(redirect_valid), 64'd0);
    endtask

    initial begin
        logic ill, ebr, ecl, mrt;
        int pick;
        // Power-on reset
        tick();
        tick();
        chk_all_zero("por");
        reset = 1'b1;
        tick();

        // Abort an ecall mid-REDIR with a 2-cycle reset
        mtvec = 64'h8000_0100;
        commit_valid = 1'b1; commit_pc = 64'h8000_0010; commit_ecall = 1'b1;
        tick();
        quiet();
        tick();
        tick();
        chk("pre_reset_rv", 64'(redirect_valid), 64'd1);
        reset = 1'b0;
        tick();
        chk_all_zero("rst1");
        tick();
        chk_all_zero("rst2");
        reset = 1'b1;
        tick();

        // Directed plan items
        run_txn(64'h8000_0010, 64'h8000_0014, 0, 0, 1, 0, 0, 0, 64'h8000_0100, 64'h0, 0, 0);
        run_txn(64'h8000_0020, 64'h8000_0024, 0, 0, 0, 0, 1, 1, 64'h8000_0100, 64'h0, 0, 0);
        run_txn(64'h8000_0020, 64'h8000_0024, 0, 0, 0, 0, 0, 1, 64'h8000_0100, 64'h0, 0, 1);
        run_txn(64'h8000_0030, 64'h8000_0034, 1, 0, 0, 0, 1, 0, 64'h8000_0100, 64'h0, 4, 0);
        run_txn(64'h8000_0040, 64'h8000_0044, 0, 0, 0, 1, 1, 1, 64'h8000_0100, 64'h8000_0200, 0, 5);
        run_txn(64'h8000_0050, 64'h8000_0054, 0, 1, 1, 0, 0, 0, 64'h8000_0101, 64'h0, 1, 0);
        run_txn(64'h8000_0060, 64'h8000_0064, 0, 0, 0, 0, 0, 1, 64'h8000_0101, 64'h0, 0, 0);
        run_txn(64'h8000_0070, 64'h8000_0074, 0, 0, 1, 0, 0, 1, 64'h8000_0101, 64'h0, 0, 0);
        run_txn(64'h8000_0080, 64'h8000_0084, 0, 0, 0, 0, 0, 0, 64'h8000_0101, 64'h0, 0, 0);

        // Randomized transactions
        for (int n = 0; n < 60; n++) begin
            pick = int'($urandom_range(0, 5));
            ill = (pick == 0); ebr = (pick == 1) || (pick == 0 && 1'($urandom));
            ecl = (pick == 2) || 1'($urandom_range(0, 3) == 0);
            mrt = (pick == 3) || 1'($urandom_range(0, 3) == 0);
            run_txn({$urandom, $urandom}, {$urandom, $urandom}, ill, ebr, ecl, mrt,
                    1'($urandom), 1'($urandom),
                    {$urandom, $urandom[31:2], 2'($urandom_range(0, 1))}, {$urandom, $urandom},
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ysyx_040729_trap_ctrl.md
Name: ysyx_040729_trap_ctrl

Overview:
- Sequences the machine-mode CSR file for trap entry and return.
- Watches instruction commit, synchronous exception flags and masked interrupt lines (eirp/tirp after the mstatus.MIE/mie gating in the CSR file). Prioritises them.
- Waits for in-flight memory traffic to drain, then issues the one-cycle exception/mret strobe with mepc/mcause data.
- Hands the new fetch PC to the IFU through a valid/ready redirect handshake. Sits between the commit stage, the CSR file and the fetch unit.

Parameters:
- DATA_WIDTH, 64, width of PC, mtvec, mepc, mcause.
- CAUSE_EXT, 11, interrupt code for machine external interrupt.
- CAUSE_TMR, 7, interrupt code for machine timer interrupt.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- commit_valid  in  1  one instruction commits this cycle.
- commit_pc  in  DATA_WIDTH  PC of committing instruction.
- commit_npc  in  DATA_WIDTH  architectural next PC of committing instruction.
- commit_ecall  in  1  committing instruction is ecall.
- commit_ebreak  in  1  committing instruction is ebreak.
- commit_illegal  in  1  committing instruction is illegal.
- commit_mret  in  1  committing instruction is mret.
- eirp  in  1  masked external interrupt (CSR eirp_o).
- tirp  in  1  masked timer interrupt (CSR tirp_o).
- lsu_busy  in  1  outstanding load/store not yet complete.
- mtvec  in  DATA_WIDTH  current mtvec (CSR visible copy).
- mepc  in  DATA_WIDTH  current mepc (CSR visible copy).
- csr_exception  out  1  trap-entry strobe to CSR.
- csr_mret  out  1  mret strobe to CSR.
- csr_mepc_hwdata  out  DATA_WIDTH  mepc value for trap entry.
- csr_mcause_hwdata  out  DATA_WIDTH  mcause value for trap entry.
- stall  out  1  freeze fetch/decode/commit.
- redirect_valid  out  1  redirect PC offered to IFU.
- redirect_pc  out  DATA_WIDTH  target PC.
- redirect_ready  in  1  IFU accepts redirect.

Behaviour:
- Reset (reset==0 at posedge): state IDLE, all outputs 0, capture registers 0. Reset mid-sequence aborts immediately and drops any pending redirect.
- States: IDLE, DRAIN, FIRE, REDIR.
- Event detect happens in IDLE only, on commit_valid.
- Priority: illegal (cause 2) > ebreak (3) > ecall (11) > mret > external irq > timer irq.
- Sync exception: mepc=commit_pc, mcause=code with bit[DATA_WIDTH-1]=0.
- Interrupt: the instruction completes; mepc=commit_npc, mcause={1'b1, zero-extended code}. An interrupt is taken only on a commit without a sync event or mret. eirp/tirp sampled the same cycle.
- mret: no mepc/mcause update.
- Capture: on an event, latch kind, mepc value and cause; assert stall combinationally that cycle and keep it until the REDIR handshake completes.
- IDLE->DRAIN if lsu_busy, else IDLE->FIRE.
- DRAIN: stay while lsu_busy; ->FIRE when lsu_busy==0.
- FIRE, exactly one cycle:
  - trap: csr_exception=1, hwdata outputs driven from capture; redirect_pc latched = {mtvec[DATA_WIDTH-1:2],2'b00}.
  - mret: csr_mret=1; redirect_pc latched = mepc sampled this cycle (pre-update; mret does not write mepc).
  - Then ->REDIR.
- REDIR: redirect_valid=1, redirect_pc stable. On redirect_ready: ->IDLE, stall drops the next cycle. redirect_ready without redirect_valid is ignored.
- Minimum latency, event commit to redirect_valid: 2 cycles (IDLE->FIRE->REDIR). DRAIN adds lsu_busy cycles.
- commit_valid while not IDLE is ignored; the pipeline is stalled. Interrupts arriving then are not lost: the CSR levels persist and are re-sampled at the next commit.
- csr_mepc_hwdata/csr_mcause_hwdata are 0 outside FIRE.
- csr_exception and csr_mret are never high together.

Optional Feature:
- Macro: YSYX_040729_TRAP_VECTORED_EN.
- Defined: if mtvec[1:0]==2'b01 and the event is an interrupt, redirect_pc = {mtvec[DATA_WIDTH-1:2],2'b00} + 4*code. Exceptions always use the base.
- Undefined: mtvec[1:0] is ignored; all traps go to the base.

Test Plan:
- Reset low 2 cycles mid-REDIR -> all outputs 0, state IDLE; the next ecall still sequences normally.
- commit_ecall at pc 0x8000_0010, mtvec=0x8000_0100, lsu_busy=0, redirect_ready=1:
  - csr_exception pulses one cycle with mepc_hwdata=0x8000_0010 and mcause=11.
  - redirect_valid rises 2 cycles after commit with pc 0x8000_0100.
  - stall is high for exactly 3 cycles.
- tirp=1 and eirp=1 on a plain commit pc=0x8000_0020, npc=0x8000_0024:
  - mcause=0x8000_0000_0000_000B, mepc=0x8000_0024.
  - Repeat with only tirp -> mcause=0x8000_0000_0000_0007.
- commit_illegal with eirp=1, lsu_busy high 4 cycles:
  - stays in DRAIN 4 cycles.
  - mcause=2, mepc=commit_pc.
  - csr_exception asserts only after lsu_busy falls.
- commit_mret with mepc=0x8000_0200, redirect_ready held low 5 cycles:
  - csr_mret pulses once, csr_exception stays 0.
  - redirect_valid and pc 0x8000_0200 are stable for 5 cycles; stall is released one cycle after ready.
- With YSYX_040729_TRAP_VECTORED_EN, mtvec=0x8000_0101, timer irq -> redirect_pc=0x8000_011C. An ecall with the same mtvec goes to 0x8000_0100.
